// File: rtl/warp_mem_arbiter_if.sv
// warp_mem_arbiter_if
// Bundles the requester-side and memory-side buses of the warp memory arbiter.
//   req_*      : per-requester request handshake, packed address/data, load/store flag
//   resp_*     : one-hot read-response strobe plus shared read data
//   mem_req_*  : downstream request (valid/ready handshake) toward the RoCC memory port
//   mem_resp_* : downstream read-response beat (no back-pressure)
// Modport master is the arbiter's view; modport slave is the surrounding
// environment (lane memory units plus the engine's top-level memory port).
interface warp_mem_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          mem_req_valid;
    logic                          mem_req_ready;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic                          mem_req_write;
    logic [DATA_WIDTH-1:0]         mem_req_data;
    logic                          mem_resp_valid;
    logic [DATA_WIDTH-1:0]         mem_resp_data;

    modport master (
        input  req_valid, req_addr, req_write, req_data,
        output req_ready, resp_valid, resp_data,
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        output req_valid, req_addr, req_write, req_data,
        input  req_ready, resp_valid, resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/warp_mem_arbiter.sv
// warp_mem_arbiter
// Round-robin arbiter sharing the warp engine's single memory port among
// NUM_REQ requesters. One winner per cycle is registered into a holding stage
// that drives mem_req_*. Every accepted read pushes its requester ID into an
// in-order tag FIFO; each untagged mem_resp beat pops the head ID and is
// steered to that requester as a one-hot resp_valid strobe.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (master)        : requester and memory buses (see warp_mem_arbiter_if)
//   outstanding         : reads captured but not yet answered (tag FIFO occupancy)
//   err_unexpected_resp : sticky, a response arrived with no read outstanding
module warp_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    warp_mem_arbiter_if.master                bus,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_unexpected_resp
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    // Holding stage
    logic                  hold_valid_r;
    logic [ADDR_WIDTH-1:0] hold_addr_r;
    logic                  hold_write_r;
    logic [DATA_WIDTH-1:0] hold_data_r;

    // Arbitration
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [NUM_REQ-1:0] eligible_s;
    logic               found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               cap_en_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] req_ready_s;

    // Tag FIFO; pointers carry one extra wrap bit to tell full from empty
    logic [IDX_W-1:0] tag_mem_r [MAX_OUTSTANDING];
    logic [CNT_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] rd_ptr_r;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;
    logic [IDX_W-1:0] head_s;
    logic [NUM_REQ-1:0] resp_valid_s;

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                          (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign head_s       = tag_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign outstanding  = wr_ptr_r - rd_ptr_r;

    // A new request may be captured when the holding stage is empty or draining now
    assign cap_en_s = !hold_valid_r || bus.mem_req_ready;
    // Gated by rst_n so req_ready reads zero while reset is held
    assign accept_s = found_s && cap_en_s && rst_n;
    assign push_s   = accept_s && !bus.req_write[win_idx_s];
    assign pop_s    = bus.mem_resp_valid && !fifo_empty_s && rst_n;

    // Eligibility: reads need a free tag slot, writes never do
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = bus.req_valid[i] && (bus.req_write[i] || !fifo_full_s);
        end
    end

    // Round-robin search starting at rr_ptr_r, first eligible requester wins
    always_comb begin : arb_search
        int cand;
        found_s   = 1'b0;
        win_idx_s = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (!found_s && eligible_s[IDX_W'(cand)]) begin
                found_s   = 1'b1;
                win_idx_s = IDX_W'(cand);
            end else begin
                found_s   = found_s;
                win_idx_s = win_idx_s;
            end
        end
    end

    // One-hot grant and one-hot response strobe decode
    always_comb begin
        req_ready_s  = '0;
        resp_valid_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_s[i]  = accept_s && (win_idx_s == IDX_W'(i));
            resp_valid_s[i] = pop_s && (head_s == IDX_W'(i));
        end
    end

    assign bus.req_ready     = req_ready_s;
    assign bus.resp_valid    = resp_valid_s;
    assign bus.resp_data     = bus.mem_resp_data;
    assign bus.mem_req_valid = hold_valid_r;
    assign bus.mem_req_addr  = hold_addr_r;
    assign bus.mem_req_write = hold_write_r;
    assign bus.mem_req_data  = hold_data_r;

    // Holding stage: load the winner, otherwise drain on the downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_r <= 1'b0;
            hold_addr_r  <= '0;
            hold_write_r <= 1'b0;
            hold_data_r  <= '0;
        end else if (accept_s) begin
            hold_valid_r <= 1'b1;
            hold_addr_r  <= bus.req_addr[int'(win_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
            hold_write_r <= bus.req_write[win_idx_s];
            hold_data_r  <= bus.req_data[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        end else if (bus.mem_req_ready) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= IDX_W'((int'(win_idx_s) + 1) % NUM_REQ);
        end
    end

    // Tag FIFO: push read IDs at capture, pop on every matched response beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r[PTR_W-1:0]] <= win_idx_s;
                wr_ptr_r <= wr_ptr_r + CNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + CNT_W'(1);
            end
        end
    end

    // Sticky error: a response beat arrived with nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected_resp <= 1'b0;
        end else if (bus.mem_resp_valid && fifo_empty_s) begin
            err_unexpected_resp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_warp_mem_arbiter.sv
// Self-checking bench for warp_mem_arbiter: a table of per-cycle vectors for
// single read, fairness and in-order routing, followed by hand-written
// sequences for back-pressure, the outstanding limit, the error flag and
// asynchronous reset.
module tb_warp_mem_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] outstanding;
    logic       err;

    int pass_cnt;
    int total_cnt;

    logic [31:0] addr_map [4];
    logic [31:0] data_map [4];

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic        mready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_resp;
        int          exp_src;     // requester held downstream, -1 = mem_req_valid low
        logic        exp_mwrite;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t vecs[$];

    warp_mem_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    warp_mem_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .outstanding         (outstanding),
        .err_unexpected_resp (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] w, input logic mr,
                       input logic rv, input logic [31:0] rd, input logic [3:0] er,
                       input logic [3:0] eresp, input int src, input logic emw,
                       input logic [3:0] eout);
        vec_t t;
        t.valid = v; t.write = w; t.mready = mr; t.rvalid = rv; t.rdata = rd;
        t.exp_ready = er; t.exp_resp = eresp; t.exp_src = src;
        t.exp_mwrite = emw; t.exp_out = eout;
        vecs.push_back(t);
    endtask

    // Apply inputs at the falling edge and settle, well away from the rising edge
    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic mr,
                         input logic rv, input logic [31:0] rd);
        @(negedge clk);
        bus.req_valid      = v;
        bus.req_write      = w;
        bus.mem_req_ready  = mr;
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = rd;
        #1;
    endtask

    task automatic check_hold(input string name, input int src, input logic wr);
        check({name, "_mvalid"}, {31'd0, bus.mem_req_valid}, 32'd1);
        check({name, "_maddr"},  bus.mem_req_addr, addr_map[src]);
        check({name, "_mdata"},  bus.mem_req_data, data_map[src]);
        check({name, "_mwrite"}, {31'd0, bus.mem_req_write}, {31'd0, wr});
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        addr_map[0] = 32'h0000_0040; addr_map[1] = 32'h0000_0080;
        addr_map[2] = 32'h0000_0100; addr_map[3] = 32'h0000_0200;
        data_map[0] = 32'hDA7A_0000; data_map[1] = 32'hDA7A_0001;
        data_map[2] = 32'hDA7A_0002; data_map[3] = 32'hDA7A_0003;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*32 +: 32] = addr_map[i];
            bus.req_data[i*32 +: 32] = data_map[i];
        end

        // Reset with requests and a response beat present: outputs must stay quiet
        rst_n              = 1'b0;
        bus.req_valid      = 4'b1111;
        bus.req_write      = 4'b0000;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready",     {28'd0, bus.req_ready}, 32'd0);
        check("rst_resp",      {28'd0, bus.resp_valid}, 32'd0);
        check("rst_rdata",     bus.resp_data, 32'h1234_5678);
        check("rst_mvalid",    {31'd0, bus.mem_req_valid}, 32'd0);
        check("rst_maddr",     bus.mem_req_addr, 32'd0);
        check("rst_mwrite",    {31'd0, bus.mem_req_write}, 32'd0);
        check("rst_mdata",     bus.mem_req_data, 32'd0);
        check("rst_out",       {28'd0, outstanding}, 32'd0);
        check("rst_err",       {31'd0, err}, 32'd0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'd0);
        rst_n = 1'b1;

        // Single read by requester 2
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, -1, 1'b0, 4'd0);
        add(4'b0100, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0100, 4'b0000, -1, 1'b0, 4'd0);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000,  2, 1'b0, 4'd1);
        add(4'b0000, 4'b0000, 1'b1, 1'b1, 32'hDEADBEEF,  4'b0000, 4'b0100, -1, 1'b0, 4'd1);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, -1, 1'b0, 4'd0);
        // Requester 3 write brings the pointer back to 0
        add(4'b1000, 4'b1000, 1'b1, 1'b0, 32'h0,         4'b1000, 4'b0000, -1, 1'b0, 4'd0);
        // Fairness: all four writing
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0001, 4'b0000,  3, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0010, 4'b0000,  0, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0100, 4'b0000,  1, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b1000, 4'b0000,  2, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0001, 4'b0000,  3, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0010, 4'b0000,  0, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0100, 4'b0000,  1, 1'b1, 4'd0);
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b1000, 4'b0000,  2, 1'b1, 4'd0);
        // Requester 1 drops out: 0,2,3,0
        add(4'b1101, 4'b1101, 1'b1, 1'b0, 32'h0,         4'b0001, 4'b0000,  3, 1'b1, 4'd0);
        add(4'b1101, 4'b1101, 1'b1, 1'b0, 32'h0,         4'b0100, 4'b0000,  0, 1'b1, 4'd0);
        add(4'b1101, 4'b1101, 1'b1, 1'b0, 32'h0,         4'b1000, 4'b0000,  2, 1'b1, 4'd0);
        add(4'b1101, 4'b1101, 1'b1, 1'b0, 32'h0,         4'b0001, 4'b0000,  3, 1'b1, 4'd0);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000,  0, 1'b1, 4'd0);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, -1, 1'b0, 4'd0);
        // In-order routing: reads from 1, 3, 0 then responses A, B, C
        add(4'b0010, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0010, 4'b0000, -1, 1'b0, 4'd0);
        add(4'b1000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b1000, 4'b0000,  1, 1'b0, 4'd1);
        add(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0001, 4'b0000,  3, 1'b0, 4'd2);
        add(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_000A, 4'b0000, 4'b0010,  0, 1'b0, 4'd3);
        add(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_000B, 4'b0000, 4'b1000, -1, 1'b0, 4'd2);
        // Same-cycle push (requester 2) and pop (head 0)
        add(4'b0100, 4'b0000, 1'b1, 1'b1, 32'h0000_000C, 4'b0100, 4'b0001, -1, 1'b0, 4'd1);
        add(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_000E, 4'b0000, 4'b0100,  2, 1'b0, 4'd1);
        add(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, -1, 1'b0, 4'd0);

        foreach (vecs[n]) begin
            drive(vecs[n].valid, vecs[n].write, vecs[n].mready, vecs[n].rvalid, vecs[n].rdata);
            check($sformatf("v%0d_ready", n), {28'd0, bus.req_ready}, {28'd0, vecs[n].exp_ready});
            check($sformatf("v%0d_resp", n), {28'd0, bus.resp_valid}, {28'd0, vecs[n].exp_resp});
            check($sformatf("v%0d_out", n), {28'd0, outstanding}, {28'd0, vecs[n].exp_out});
            if (vecs[n].exp_resp != 4'b0000) begin
                check($sformatf("v%0d_rdata", n), bus.resp_data, vecs[n].rdata);
            end
            if (vecs[n].exp_src < 0) begin
                check($sformatf("v%0d_mvalid", n), {31'd0, bus.mem_req_valid}, 32'd0);
            end else begin
                check_hold($sformatf("v%0d", n), vecs[n].exp_src, vecs[n].exp_mwrite);
            end
        end

        // Back-pressure: requester 2 captured with mem_req_ready low, then held 5 cycles
        drive(4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0);
        check("bp_first_grant", {28'd0, bus.req_ready}, 32'b0100);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0011, 4'b0000, 1'b0, 1'b0, 32'h0);
            check($sformatf("bp%0d_ready", c), {28'd0, bus.req_ready}, 32'd0);
            check_hold($sformatf("bp%0d", c), 2, 1'b0);
        end
        drive(4'b0011, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("bp_release_grant", {28'd0, bus.req_ready}, 32'b0001);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_0055);
        check("bp_resp0", {28'd0, bus.resp_valid}, 32'b0100);
        check_hold("bp_next", 0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_0066);
        check("bp_resp1", {28'd0, bus.resp_valid}, 32'b0001);

        // Outstanding limit: eight reads fill the tag FIFO
        for (int c = 0; c < 8; c++) begin
            drive(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
            check($sformatf("fill%0d_grant", c), {28'd0, bus.req_ready}, 32'b0001);
        end
        drive(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("full_out", {28'd0, outstanding}, 32'd8);
        check("full_read_blocked", {28'd0, bus.req_ready}, 32'd0);
        drive(4'b0011, 4'b0010, 1'b1, 1'b0, 32'h0);
        check("full_write_ok", {28'd0, bus.req_ready}, 32'b0010);
        drive(4'b0001, 4'b0000, 1'b1, 1'b1, 32'h0000_0077);
        check("full_pop_still_blocked", {28'd0, bus.req_ready}, 32'd0);
        check("full_pop_resp", {28'd0, bus.resp_valid}, 32'b0001);
        drive(4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("after_pop_out", {28'd0, outstanding}, 32'd7);
        check("after_pop_grant", {28'd0, bus.req_ready}, 32'b0001);
        for (int c = 0; c < 8; c++) begin
            drive(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_0100 + 32'(c));
            check($sformatf("drain%0d_resp", c), {28'd0, bus.resp_valid}, 32'b0001);
        end
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("drained_out", {28'd0, outstanding}, 32'd0);

        // Unexpected response with empty FIFO
        drive(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0000_0099);
        check("unexp_resp_dropped", {28'd0, bus.resp_valid}, 32'd0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("unexp_err_set", {31'd0, err}, 32'd1);
        check("unexp_out", {28'd0, outstanding}, 32'd0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("unexp_err_sticky", {31'd0, err}, 32'd1);

        // Asynchronous reset mid-burst with the holding stage stalled
        drive(4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0);
        drive(4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0000_00AB);
        check("pre_rst_mvalid", {31'd0, bus.mem_req_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mvalid", {31'd0, bus.mem_req_valid}, 32'd0);
        check("arst_maddr",  bus.mem_req_addr, 32'd0);
        check("arst_mdata",  bus.mem_req_data, 32'd0);
        check("arst_mwrite", {31'd0, bus.mem_req_write}, 32'd0);
        check("arst_out",    {28'd0, outstanding}, 32'd0);
        check("arst_err",    {31'd0, err}, 32'd0);
        check("arst_ready",  {28'd0, bus.req_ready}, 32'd0);
        check("arst_resp",   {28'd0, bus.resp_valid}, 32'd0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        drive(4'b0110, 4'b0000, 1'b1, 1'b0, 32'h0);
        check("post_rst_grant", {28'd0, bus.req_ready}, 32'b0010);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/warp_mem_arbiter.md
# warp_mem_arbiter

Round-robin arbiter that shares the warp engine's single RoCC memory port among `NUM_REQ` internal requesters (lane load/store units, instruction fetch). It registers one winning request per cycle into a holding stage that drives the downstream memory request. It records the requester ID of every issued read in an in-order tag FIFO, so that untagged `mem_resp` beats are routed back to the correct requester. The block sits between the lane memory units and the engine's top-level `mem_req_*` / `mem_resp_*` ports.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `ADDR_WIDTH`, 32: address width
- `DATA_WIDTH`, 32: data width
- `MAX_OUTSTANDING`, 8: tag FIFO depth, i.e. the maximum number of reads in flight (power of 2)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_write`  in  NUM_REQ  1 = store, 0 = load
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed store data
- `resp_valid`  out  NUM_REQ  one-hot read-response strobe
- `resp_data`  out  DATA_WIDTH  read data, shared by all requesters
- `mem_req_valid`  out  1  downstream request valid
- `mem_req_ready`  in  1  downstream accept
- `mem_req_addr`  out  ADDR_WIDTH  downstream address
- `mem_req_write`  out  1  downstream write flag
- `mem_req_data`  out  DATA_WIDTH  downstream write data
- `mem_resp_valid`  in  1  read response beat; no ready, must be consumed
- `mem_resp_data`  in  DATA_WIDTH  read response data
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  reads captured but not yet answered
- `err_unexpected_resp`  out  1  sticky flag: a response arrived with the tag FIFO empty

## Operation
- **Holding stage** (`hold_valid`, addr, write, data):
  - Drives `mem_req_*` directly.
  - Clears on `mem_req_valid && mem_req_ready`.
- **Capture enable:** `cap_en = !hold_valid || mem_req_ready`.
- **Eligibility:** requester i is eligible when `req_valid[i]` and, if `req_write[i]==0`, the tag FIFO is not full. Writes never need a tag.
- **Round-robin arbitration:**
  - Search starts at `rr_ptr` and wraps modulo NUM_REQ.
  - The first eligible requester wins.
  - `req_ready[winner]=1` only when `cap_en`; all other bits are 0.
- **On acceptance** (`req_valid[i] && req_ready[i]`):
  - The holding stage loads requester i's fields.
  - `rr_ptr <= (i+1) mod NUM_REQ`.
  - For a read, i is pushed into the tag FIFO.
- `rr_ptr` does not move on cycles with no acceptance.
- **Response routing:** on `mem_resp_valid`, the FIFO head ID h is popped in the same cycle.
  - `resp_valid = 1<<h`.
  - `resp_data = mem_resp_data`, combinational pass-through.
- **Writes** produce no response.
- **Unexpected response** (`mem_resp_valid` with the FIFO empty):
  - `resp_valid` stays 0 and the beat is dropped.
  - `err_unexpected_resp` is set and held until reset.
- **Push and pop in the same cycle:** both occur and `outstanding` is unchanged.
- **FIFO full:** reads are blocked even if a pop happens in the same cycle; space frees on the next cycle.
- **`outstanding`** equals the FIFO occupancy, range 0..MAX_OUTSTANDING.
- **Address/data width:** passed through unmodified. No arithmetic beyond pointer wrap (FIFO pointers wrap modulo MAX_OUTSTANDING, with an extra bit for full/empty).

## Timing
- **Reset values:**
  - `mem_req_valid=0`; `mem_req_addr/write/data=0`.
  - `req_ready=0`, `resp_valid=0`, `resp_data` follows input.
  - `outstanding=0`, `err_unexpected_resp=0`, `rr_ptr=0`.
- **Reset asserted mid-operation:**
  - Asynchronously clears the holding stage, tag FIFO, pointer and error flag.
  - In-flight reads are forgotten; the downstream memory must be reset together with this block.
- **Request latency:** acceptance in cycle T gives `mem_req_valid=1` in T+1.
- **Back-to-back throughput:** one request per cycle while `mem_req_ready=1`.
- **Back-pressure:**
  - While `mem_req_valid && !mem_req_ready`, all `mem_req_*` outputs are held stable and `req_ready` is all-zero.
  - `mem_req_valid` never drops without a handshake.
- **Combinational paths:**
  - `mem_req_ready` and `req_valid` to `req_ready`.
  - `mem_resp_valid` / `mem_resp_data` to `resp_valid` / `resp_data`.
  - The FIFO pop itself is registered.
- **Response to same-cycle request:** a response cannot belong to a request still in the holding stage; ordering is guaranteed because the push occurs at capture.

## Test plan
- **Single read:** requester 2 reads addr 0x100 → `req_ready=4'b0100` same cycle; next cycle `mem_req_valid=1`, addr 0x100, write 0, `outstanding=1`. Then `mem_resp` 0xDEADBEEF → `resp_valid=4'b0100`, `resp_data=0xDEADBEEF`, `outstanding=0`.
- **Fairness:** all 4 requesters hold `req_valid` with `mem_req_ready=1` for 8 cycles → grant order 0,1,2,3,0,1,2,3. If requester 1 drops out → order 0,2,3,0.
- **Back-pressure:** `mem_req_ready=0` for 5 cycles with a request held → `mem_req_*` constant, `req_ready=0`. On release, the next grant goes to `rr_ptr`.
- **Outstanding limit:**
  - 8 reads with no responses → `outstanding=8`; a 9th read from requester 0 is blocked.
  - A write from requester 1 is still accepted.
  - One response → requester 0 is accepted the following cycle.
- **In-order routing:** reads issued by requesters 1, 3, 0, then three responses 0xA, 0xB, 0xC → `resp_valid` 4'b0010, 4'b1000, 4'b0001 with matching data. A same-cycle push and pop keeps `outstanding` unchanged.
- **Error and reset:**
  - `mem_resp_valid` with an empty FIFO → `err_unexpected_resp=1`, `resp_valid=0`.
  - Asserting `rst_n=0` mid-burst → all outputs reach their reset values without waiting for a clock edge.
